accum_adder: RTL and testbench
==============================

# accum_adder

Parametrised, pipelined multi-lane signed adder with packet accumulation and a valid/ready handshake. It is the successor to the 16-bit combinational two-operand `adder`. Each accepted beat carries LANES signed operands, which are reduced through a registered adder tree. Beat sums are accumulated across a packet delimited by `in_last`, and one result is emitted per packet, clamped to WIDTH bits. It sits between the multiplier array and the activation stage of the neuron datapath.

## Interface
- WIDTH, 16: operand and result width, signed two's complement.
- LANES, 4: operands per beat; power of two, ≥2.
- GUARD, 8: extra accumulator headroom bits.
- LOG2L (derived): $clog2(LANES). ACCW (derived): WIDTH+LOG2L+GUARD.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH], signed.
- in_last  in  1  beat is the final beat of its packet.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  packet result, signed.
- out_sat  out  1  result was clamped (see Configuration).

## Operation
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- Global stall: stall = out_valid && !out_ready. in_ready = !stall (combinational).
- Behaviour during stall: every pipeline register, the accumulator and the output hold their values.
- Adder tree: LOG2L registered levels. Each level pairwise-adds with sign extension and grows 1 bit per level. The tree is exact and never overflows. Each level carries a valid bit and a last bit alongside its data.
- Accumulate stage, non-last beat: acc ← acc + beat_sum, computed at ACCW bits.
- Accumulate stage, last beat: the final value is acc + beat_sum. That value is clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1] and loaded into out_sum. out_valid is set, and acc is cleared to 0.
- out_sat = 1 when the WIDTH clamp fires or the sticky packet flag is set.
- Sticky flag: set if the accumulator itself saturated at its ACCW limits during the packet; cleared on the last beat.
- Output register: out_valid drops when out_ready is high and no new result is loaded that cycle.
- Simultaneous drain and load: a new result may load in the same cycle the old one drains, with no bubble.
- Packets may be any length ≥1 beat. Back-to-back packets need no idle cycle.

## Timing
- Latency: a last beat accepted at edge T gives out_valid=1 after edge T+LOG2L+1 (3 cycles for LANES=4), provided there is no stall.
- Throughput: one beat per cycle when out_ready is held high.
- Reset values: out_valid=0, out_sum=0, out_sat=0, acc=0, sticky=0, all stage valids 0.
- in_ready is 1 in the cycle after reset.
- Reset in mid-packet: the partial accumulation and all in-flight beats are discarded, and no result is emitted for them.
- Reset has priority over every other event in the same cycle.
- Stall entry and release: stall takes effect in the same cycle out_valid && !out_ready holds, and releases the cycle out_ready rises. Results leave strictly in packet order.

## Configuration
- Macro: ACCUM_SATURATE_EN.
- Defined: saturating accumulator and WIDTH clamp, as described under Operation.
- Undefined: the accumulator wraps at ACCW bits and out_sum is the low WIDTH bits of the final sum (two's complement truncation). out_sat is tied to 0 and the sticky logic is removed.

## Test plan
- Single-beat packet: lanes {1000, 2000, −500, 1500}, last=1 → out_sum=4000, out_sat=0, out_valid 3 cycles after acceptance.
- Two-beat packet: beat {1000, 2000, 3000, 4000} then {−1000, 0, 0, 0} with last=1 → one result, out_sum=9000.
- Positive overflow: all lanes 0x7FFF, last=1 → out_sum=0x7FFF, out_sat=1. Without the macro: out_sum=0xFFFC (−4), out_sat=0.
- Negative overflow: all lanes −32768, last=1 → out_sum=−32768, out_sat=1. Without the macro: out_sum=0, out_sat=0.
- Backpressure: hold out_ready=0 with a result pending and feed two more packets (sums 10 and 20). Required: in_ready=0 and out_sum stable while stalled; after release, outputs are 10 then 20 in order with no loss.
- Reset in mid-packet: non-last beat summing to 5000, then rst for one cycle, then single beat {1, 0, 0, 0}, last=1 → out_sum=1, with no carry-over from the discarded packet.

Source files
------------

// File: rtl/accum_adder.sv
// accum_adder: pipelined LANES-way signed adder tree with per-packet accumulation.
// Define ACCUM_SATURATE_EN for a saturating accumulator, WIDTH clamp and out_sat reporting.
module accum_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 4,
    parameter int unsigned GUARD = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_sum,
    output logic                   out_sat
);
    localparam int unsigned LOG2L = $clog2(LANES);
    localparam int unsigned ACCW  = WIDTH + LOG2L + GUARD;
    localparam int unsigned TreeW = WIDTH + LOG2L;
    localparam int unsigned NumSt = LOG2L + 1;

    logic                   out_valid_q;
    logic [WIDTH-1:0]       out_sum_q;
    logic                   out_sat_q;
    logic signed [ACCW-1:0] acc_q;
    logic                   stall;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;

    logic signed [TreeW-1:0] lane_ext [LANES];

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_ext[k] = TreeW'($signed(in_data[k*WIDTH +: WIDTH]));
        end
    end

    // Stage 0 registers the lanes; stages 1..LOG2L each halve the operand count.
    logic signed [TreeW-1:0] st_q [NumSt][LANES];
    logic [NumSt-1:0]        st_vld_q;
    logic [NumSt-1:0]        st_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_vld_q  <= '0;
            st_last_q <= '0;
            for (int l = 0; l < NumSt; l++) begin
                for (int k = 0; k < LANES; k++) begin
                    st_q[l][k] <= '0;
                end
            end
        end else if (!stall) begin
            st_vld_q  <= {st_vld_q[NumSt-2:0], in_valid};
            st_last_q <= {st_last_q[NumSt-2:0], in_last};
            for (int k = 0; k < LANES; k++) begin
                st_q[0][k] <= lane_ext[k];
            end
            for (int l = 1; l < NumSt; l++) begin
                for (int k = 0; k < LANES / 2; k++) begin
                    st_q[l][k] <= st_q[l-1][2*k] + st_q[l-1][2*k+1];
                end
                for (int k = LANES / 2; k < LANES; k++) begin
                    st_q[l][k] <= '0;
                end
            end
        end
    end

    logic signed [TreeW-1:0] beat_sum;
    logic                    beat_vld;
    logic                    beat_last;
    logic signed [ACCW-1:0]  acc_next;
    logic [WIDTH-1:0]        res_sum;
    logic                    res_sat;

    assign beat_sum  = st_q[NumSt-1][0];
    assign beat_vld  = st_vld_q[NumSt-1];
    assign beat_last = st_last_q[NumSt-1];

`ifdef ACCUM_SATURATE_EN
    localparam int unsigned SumW = ACCW + 1;
    localparam logic signed [ACCW-1:0] AccMax = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] AccMin = {1'b1, {(ACCW-1){1'b0}}};
    localparam logic signed [ACCW-1:0] OutMax = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] OutMin = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [SumW-1:0] sum_wide;
    logic                   acc_ovf;
    logic                   sticky_q;
    logic                   sticky_d;

    assign sum_wide = SumW'(acc_q) + SumW'(beat_sum);

    always_comb begin
        acc_ovf  = sum_wide[ACCW] != sum_wide[ACCW-1];
        acc_next = sum_wide[ACCW-1:0];
        if (acc_ovf) begin
            acc_next = sum_wide[ACCW] ? AccMin : AccMax;
        end
        res_sum = acc_next[WIDTH-1:0];
        res_sat = sticky_q | acc_ovf;
        if (acc_next > OutMax) begin
            res_sum = OutMax[WIDTH-1:0];
            res_sat = 1'b1;
        end else if (acc_next < OutMin) begin
            res_sum = OutMin[WIDTH-1:0];
            res_sat = 1'b1;
        end
        sticky_d = sticky_q;
        if (beat_vld) begin
            sticky_d = beat_last ? 1'b0 : (sticky_q | acc_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (!stall) begin
            sticky_q <= sticky_d;
        end
    end
`else
    always_comb begin
        acc_next = acc_q + ACCW'(beat_sum);
        res_sum  = acc_next[WIDTH-1:0];
        res_sat  = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else if (!stall) begin
            if (beat_vld) begin
                acc_q <= beat_last ? '0 : acc_next;
            end
            // Not stalled means any held result is being drained this cycle.
            if (beat_vld && beat_last) begin
                out_valid_q <= 1'b1;
                out_sum_q   <= res_sum;
                out_sat_q   <= res_sat;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accum_adder.sv
// Directed self-checking bench for accum_adder (WIDTH=16, LANES=4, GUARD=8).
module tb_accum_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_sat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    accum_adder #(
        .WIDTH(16),
        .LANES(4),
        .GUARD(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_sat  (out_sat)
    );

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        logic [15:0] la, lb, lc, ld;
        la = a[15:0];
        lb = b[15:0];
        lc = c[15:0];
        ld = d[15:0];
        return {ld, lc, lb, la};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (out_sum !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_out_sum: got %h expected 0000", out_sum);
        end
        n_checks++;
        if (out_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_sat: got %b expected 0", out_sat);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single_beat();
        drive(pack4(1000, 2000, -500, 1500), 1'b1);
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_valid: got %b expected 0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency_valid: got %b expected 1", out_valid);
        end
        n_checks++;
        if (out_sum !== 16'd4000) begin
            n_fail++;
            $display("FAIL single_sum: got %h expected %h", out_sum, 16'd4000);
        end
        n_checks++;
        if (out_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL single_sat: got %b expected 0", out_sat);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_two_beat();
        int cyc;
        drive(pack4(1000, 2000, 3000, 4000), 1'b0);
        drive(pack4(-1000, 0, 0, 0), 1'b1);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL two_beat_timeout: out_valid %b expected 1", out_valid);
        end
        n_checks++;
        if (out_sum !== 16'd9000) begin
            n_fail++;
            $display("FAIL two_beat_sum: got %h expected %h", out_sum, 16'd9000);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL two_beat_single_result: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_overflow(input logic [63:0] d, input logic [15:0] exp_sum,
                                 input logic exp_sat, input string name);
        int cyc;
        drive(d, 1'b1);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: out_valid %b expected 1", name, out_valid);
        end
        n_checks++;
        if (out_sum !== exp_sum) begin
            n_fail++;
            $display("FAIL %s_sum: got %h expected %h", name, out_sum, exp_sum);
        end
        n_checks++;
        if (out_sat !== exp_sat) begin
            n_fail++;
            $display("FAIL %s_sat: got %b expected %b", name, out_sat, exp_sat);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(pack4(7, 0, 0, 0), 1'b1);
        drive(pack4(4, 3, 2, 1), 1'b1);
        drive(pack4(5, 5, 5, 5), 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== 16'd7) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got valid %b sum %h expected 1 0007",
                         i, out_valid, out_sum);
            end
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready);
            end
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd10) begin
            n_fail++;
            $display("FAIL release_first: got valid %b sum %h expected 1 000a", out_valid, out_sum);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd20) begin
            n_fail++;
            $display("FAIL release_second: got valid %b sum %h expected 1 0014", out_valid, out_sum);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_empty: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        drive(pack4(1000, 1000, 1000, 2000), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(pack4(1, 0, 0, 0), 1'b1);
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_stray: got %b expected 0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_reset_sum: got valid %b sum %h expected 1 0001", out_valid, out_sum);
        end
        n_checks++;
        if (out_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_sat: got %b expected 0", out_sat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(pack4(1, 2, 3, 4), 1'b1);
        drive(pack4(-5, -5, -5, -5), 1'b1);
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd10) begin
            n_fail++;
            $display("FAIL b2b_first: got valid %b sum %h expected 1 000a", out_valid, out_sum);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'hFFEC) begin
            n_fail++;
            $display("FAIL b2b_second: got valid %b sum %h expected 1 ffec", out_valid, out_sum);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: got %b expected 0", out_valid);
        end
    endtask

    // Drive the 26-bit accumulator past its positive limit, then back down by 2^25.
    task automatic test_sticky();
        logic [15:0] exp_sum;
        logic        exp_sat;
`ifdef ACCUM_SATURATE_EN
        exp_sum = 16'hFFFF;
        exp_sat = 1'b1;
`else
        exp_sum = 16'hFBF0;
        exp_sat = 1'b0;
`endif
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = pack4(32767, 32767, 32767, 32767);
        repeat (260) tick();
        in_data = pack4(-32768, -32768, -32768, -32768);
        repeat (255) tick();
        test_overflow(in_data, exp_sum, exp_sat, "sticky");
        test_overflow(pack4(1, 0, 0, 0), 16'd1, 1'b0, "sticky_clear");
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_two_beat();
`ifdef ACCUM_SATURATE_EN
        test_overflow(pack4(32767, 32767, 32767, 32767), 16'h7FFF, 1'b1, "pos_ovf");
        test_overflow(pack4(-32768, -32768, -32768, -32768), 16'h8000, 1'b1, "neg_ovf");
`else
        test_overflow(pack4(32767, 32767, 32767, 32767), 16'hFFFC, 1'b0, "pos_ovf");
        test_overflow(pack4(-32768, -32768, -32768, -32768), 16'h0000, 1'b0, "neg_ovf");
`endif
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_sticky();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
